mem_access_unit: RTL and testbench

Parametrised data-memory access unit for the MEM stage. Replaces the single-cycle combinational arbiter interface with a req/gnt/rvalid handshake of variable latency, and raises a pipeline stall while an access is outstanding. Supports byte/half/word/dword accesses over a DATA_W-wide bus, plus LL/SC with snoop-invalidated reservations. Sits between the EX/MEM register and the memory arbiter.

---
 rtl/mem_access_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/gnt/rvalid bus handshake, byte-lane steering, LL/SC reservation.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned accesses complete locally with misalign=1.
module mem_access_unit #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RESV_GRAN = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_stall,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            m_size,
    input  logic                  atomic,
    input  logic                  zero_ext,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     rt_data,
    output logic                  arb_req,
    input  logic                  arb_gnt,
    output logic [ADDR_W-1:0]     arb_addr,
    output logic [DATA_W/8-1:0]   arb_we,
    output logic [DATA_W-1:0]     arb_wdata,
    input  logic                  arb_rvalid,
    input  logic [DATA_W-1:0]     arb_rdata,
    input  logic                  snoop_valid,
    input  logic [ADDR_W-1:0]     snoop_addr,
    output logic                  mem_busy,
    output logic                  wb_valid,
    output logic [DATA_W-1:0]     load_data,
    output logic                  sc_success,
    output logic                  misalign
);

    localparam int unsigned NB_W   = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(NB_W);
    localparam int unsigned GRAN_W = ADDR_W - RESV_GRAN;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic              access_c;
    logic              is_sc_c;
    logic              sc_pass_c;
    logic              misalign_c;
    logic              skip_bus_c;
    logic              ld_cap_c;
    logic              sc_done_c;
    logic [1:0]        size_c;
    logic [OFF_W-1:0]  off_raw_c;
    logic [OFF_W-1:0]  size_mask_c;
    logic [OFF_W-1:0]  off_c;
    logic [NB_W-1:0]   lane_c;
    logic [GRAN_W-1:0] addr_gran_c;
    logic [GRAN_W-1:0] snoop_gran_c;
    logic              snoop_unused_c;

    logic [1:0]        size_q;
    logic              zext_q;
    logic              is_load_q;
    logic              is_sc_q;
    logic              is_ll_q;
    logic [OFF_W-1:0]  off_q;
    logic [GRAN_W-1:0] req_gran_q;
    logic              resv_valid_q;
    logic [GRAN_W-1:0] resv_gran_q;

    // Select the addressed field of a read beat and sign/zero-extend it
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] raw,
                                                  input logic [OFF_W-1:0]  off,
                                                  input logic [1:0]        size,
                                                  input logic              zext);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] mask;
        logic              sign;
        sh = raw >> {off, 3'b000};
        case (size)
            2'b00:   begin mask = DATA_W'(8'hFF);         sign = sh[7];        end
            2'b01:   begin mask = DATA_W'(16'hFFFF);      sign = sh[15];       end
            2'b10:   begin mask = DATA_W'(32'hFFFF_FFFF); sign = sh[31];       end
            default: begin mask = '1;                     sign = sh[DATA_W-1]; end
        endcase
        return (sh & mask) | ((!zext && sign) ? ~mask : '0);
    endfunction

    // Request decode: effective size, lane offset, alignment and SC outcome
    always_comb begin
        access_c = mem_read | mem_write;
        is_sc_c  = mem_write & atomic & ~mem_read;
        size_c   = (DATA_W == 32 && m_size == 2'b11) ? 2'b10 : m_size;
        off_raw_c = addr[OFF_W-1:0];
        case (size_c)
            2'b00:   begin size_mask_c = '0;        lane_c = NB_W'(1);     end
            2'b01:   begin size_mask_c = OFF_W'(1); lane_c = NB_W'(3);     end
            2'b10:   begin size_mask_c = OFF_W'(3); lane_c = NB_W'(15);    end
            default: begin size_mask_c = OFF_W'(7); lane_c = NB_W'(8'hFF); end
        endcase
        misalign_c   = |(off_raw_c & size_mask_c);
        off_c        = TRAP_EN ? off_raw_c : (off_raw_c & ~size_mask_c);
        addr_gran_c  = addr[ADDR_W-1:RESV_GRAN];
        snoop_gran_c = snoop_addr[ADDR_W-1:RESV_GRAN];
        snoop_unused_c = ^snoop_addr[RESV_GRAN-1:0];
        sc_pass_c    = resv_valid_q && (resv_gran_q == addr_gran_c);
        skip_bus_c   = (TRAP_EN && misalign_c) || (is_sc_c && !sc_pass_c);
    end

    // Next state, stall request and capture strobes
    always_comb begin
        state_d   = state_q;
        mem_busy  = 1'b0;
        ld_cap_c  = 1'b0;
        sc_done_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_c) begin
                    mem_busy = 1'b1;
                    if (skip_bus_c) begin
                        state_d   = DONE;
                        sc_done_c = is_sc_c;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                mem_busy = 1'b1;
                if (arb_gnt) begin
                    if (is_load_q) begin
                        if (arb_rvalid) begin
                            state_d  = DONE;
                            ld_cap_c = 1'b1;
                        end else begin
                            state_d = WAIT;
                        end
                    end else begin
                        state_d   = DONE;
                        sc_done_c = is_sc_q;
                    end
                end
            end
            WAIT: begin
                mem_busy = 1'b1;
                if (arb_rvalid) begin
                    state_d  = DONE;
                    ld_cap_c = 1'b1;
                end
            end
            DONE: begin
                if (!pipe_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, bus request registers and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            arb_req    <= 1'b0;
            arb_addr   <= '0;
            arb_we     <= '0;
            arb_wdata  <= '0;
            wb_valid   <= 1'b0;
            load_data  <= '0;
            sc_success <= 1'b0;
            size_q     <= '0;
            zext_q     <= 1'b0;
            is_load_q  <= 1'b0;
            is_sc_q    <= 1'b0;
            is_ll_q    <= 1'b0;
            off_q      <= '0;
            req_gran_q <= '0;
        end else begin
            state_q  <= state_d;
            arb_req  <= (state_d == REQ);
            wb_valid <= (state_d == DONE);
            if (state_q == IDLE && access_c) begin
                arb_addr   <= {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                arb_we     <= (mem_write && !mem_read && !skip_bus_c) ? (lane_c << off_c) : '0;
                arb_wdata  <= rt_data << {off_c, 3'b000};
                size_q     <= size_c;
                zext_q     <= zero_ext;
                is_load_q  <= mem_read;
                is_sc_q    <= is_sc_c;
                is_ll_q    <= mem_read & atomic;
                off_q      <= off_c;
                req_gran_q <= addr_gran_c;
                sc_success <= 1'b0;
                if (TRAP_EN && misalign_c) begin
                    load_data <= '0;
                end
            end
            if (ld_cap_c) begin
                load_data <= extract(arb_rdata, off_q, size_q, zext_q);
            end
            if (state_q == REQ && arb_gnt && is_sc_q) begin
                sc_success <= 1'b1;
            end
        end
    end

    // LL/SC reservation; a matching snoop beats a same-cycle LL capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_valid_q <= 1'b0;
            resv_gran_q  <= '0;
        end else if (sc_done_c) begin
            resv_valid_q <= 1'b0;
        end else if (ld_cap_c && is_ll_q) begin
            resv_gran_q  <= req_gran_q;
            resv_valid_q <= !(snoop_valid && snoop_gran_c == req_gran_q);
        end else if (snoop_valid && resv_valid_q && snoop_gran_c == resv_gran_q) begin
            resv_valid_q <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (state_q == IDLE && access_c) begin
            misalign_q <= misalign_c;
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver pushes expected bus/result records,
// two monitors pop and compare them when the DUT raises arb_req or wb_valid.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_stall, mem_read, mem_write, atomic, zero_ext;
    logic [1:0]  m_size;
    logic [31:0] addr, rt_data;
    logic        arb_req, arb_gnt, arb_rvalid;
    logic [31:0] arb_addr, arb_wdata, arb_rdata;
    logic [3:0]  arb_we;
    logic        snoop_valid;
    logic [31:0] snoop_addr;
    logic        mem_busy, wb_valid, sc_success, misalign;
    logic [31:0] load_data;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .RESV_GRAN(2)) dut (
        .clk(clk), .rst_n(rst_n), .pipe_stall(pipe_stall),
        .mem_read(mem_read), .mem_write(mem_write), .m_size(m_size),
        .atomic(atomic), .zero_ext(zero_ext), .addr(addr), .rt_data(rt_data),
        .arb_req(arb_req), .arb_gnt(arb_gnt), .arb_addr(arb_addr), .arb_we(arb_we),
        .arb_wdata(arb_wdata), .arb_rvalid(arb_rvalid), .arb_rdata(arb_rdata),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .mem_busy(mem_busy),
        .wb_valid(wb_valid), .load_data(load_data), .sc_success(sc_success),
        .misalign(misalign)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        chk_wd;
    } bus_exp_t;

    typedef struct packed {
        logic        chk_ld;
        logic [31:0] ld;
        logic        sc;
        logic        mis;
    } res_exp_t;

    bus_exp_t    bus_q[$];
    res_exp_t    res_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          resv_v = 1'b0;
    logic [31:0] resv_g = '0;
    logic [31:0] last_ll = 32'h3000;
    logic [31:0] bases[4] = '{32'h1000, 32'h3000, 32'h3004, 32'h2000};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        return bases[$urandom % 4] + 32'($urandom % 8);
    endfunction

    // Reference model: expected bus beat and writeback for one access
    function automatic void model(input int kind, input logic [1:0] size, input logic zext,
                                  input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                                  output bit bus, output bus_exp_t b, output res_exp_t r);
        int     n;
        int     off;
        bit     trap;
        bit     is_ld;
        bit     is_sc;
        bit     sc_ok;
        longint span;
        longint field;
        n     = (size == 2'd3) ? 4 : (1 << size);
        off   = int'(a % 4);
        trap  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap  = (a % 32'(n)) != 0;
`else
        off   = off - (off % n);
`endif
        is_ld = (kind == 0) || (kind == 2);
        is_sc = (kind == 3);
        sc_ok = resv_v && ((a >> 2) == resv_g);
        bus   = !trap && !(is_sc && !sc_ok);
        b.addr   = a & 32'hFFFF_FFFC;
        b.we     = is_ld ? 4'h0 : 4'(((1 << n) - 1) << off);
        b.wdata  = 32'(longint'(d) << (8 * off));
        b.chk_wd = !is_ld;
        span  = longint'(1) << (8 * n);
        field = (longint'(rd) >> (8 * off)) % span;
        if (!zext && field >= span / 2) field = field - span;
        r.chk_ld = is_ld || trap;
        r.ld     = trap ? 32'h0 : 32'(field);
        r.sc     = is_sc && bus;
        r.mis    = trap;
    endfunction

    // kind: 0 load, 1 store, 2 LL, 3 SC; snoop_at fires at LL data capture or SC grant
    task automatic do_access(input int kind, input logic [1:0] size, input logic zext,
                             input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                             input int gd, input int rvd, input int stall,
                             input bit snoop_at, input logic [31:0] saddr);
        bit       bus;
        bit       is_ld;
        bus_exp_t b;
        res_exp_t r;
        model(kind, size, zext, a, d, rd, bus, b, r);
        is_ld = (kind == 0) || (kind == 2);
        if (bus) bus_q.push_back(b);
        res_q.push_back(r);
        @(negedge clk);
        mem_read  = is_ld;
        mem_write = !is_ld;
        atomic    = (kind >= 2);
        m_size    = size;
        zero_ext  = zext;
        addr      = a;
        rt_data   = d;
        #1 check("mem_busy_issue", 64'(mem_busy), 64'(1));
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        atomic    = 1'b0;
        if (bus) begin
            check("arb_req_raised", 64'(arb_req), 64'(1));
            repeat (gd) @(negedge clk);
            arb_gnt = 1'b1;
            if (is_ld && rvd == 0) begin
                arb_rvalid = 1'b1;
                arb_rdata  = rd;
            end
            if (snoop_at && (kind == 3 || (kind == 2 && rvd == 0))) begin
                snoop_valid = 1'b1;
                snoop_addr  = saddr;
            end
            @(negedge clk);
            arb_gnt     = 1'b0;
            arb_rvalid  = 1'b0;
            snoop_valid = 1'b0;
            if (is_ld && rvd > 0) begin
                repeat (rvd - 1) @(negedge clk);
                arb_rvalid = 1'b1;
                arb_rdata  = rd;
                if (snoop_at && kind == 2) begin
                    snoop_valid = 1'b1;
                    snoop_addr  = saddr;
                end
                @(negedge clk);
                arb_rvalid  = 1'b0;
                snoop_valid = 1'b0;
            end
            if (kind == 2) begin
                resv_g  = a >> 2;
                resv_v  = !(snoop_at && (saddr >> 2) == (a >> 2));
                last_ll = a;
            end
        end else begin
            check("arb_req_quiet", 64'(arb_req), 64'(0));
        end
        if (kind == 3) resv_v = 1'b0;
        check("wb_valid_latency", 64'(wb_valid), 64'(1));
        pipe_stall = (stall > 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("wb_valid_hold", 64'(wb_valid), 64'(1));
            if (r.chk_ld) check("load_data_hold", 64'(load_data), 64'(r.ld));
        end
        pipe_stall = 1'b0;
        @(negedge clk);
        check("wb_valid_drop", 64'(wb_valid), 64'(0));
    endtask

    task automatic gap_snoop(input logic [31:0] saddr);
        @(negedge clk);
        snoop_valid = 1'b1;
        snoop_addr  = saddr;
        if (resv_v && (saddr >> 2) == resv_g) resv_v = 1'b0;
        @(negedge clk);
        snoop_valid = 1'b0;
    endtask

    // Bus monitor: one expected beat per rising arb_req
    initial begin : bus_mon
        bit       req_prev;
        bus_exp_t e;
        req_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && arb_req && !req_prev) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected_req", 64'(arb_req), 64'(0));
                end else begin
                    e = bus_q.pop_front();
                    check("arb_addr", 64'(arb_addr), 64'(e.addr));
                    check("arb_we", 64'(arb_we), 64'(e.we));
                    if (e.chk_wd) check("arb_wdata", 64'(arb_wdata), 64'(e.wdata));
                end
            end
            req_prev = arb_req;
        end
    end

    // Result monitor: one expected writeback per rising wb_valid
    initial begin : res_mon
        bit       wb_prev;
        res_exp_t e;
        wb_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && wb_valid && !wb_prev) begin
                if (res_q.size() == 0) begin
                    check("wb_unexpected", 64'(wb_valid), 64'(0));
                end else begin
                    e = res_q.pop_front();
                    if (e.chk_ld) check("load_data", 64'(load_data), 64'(e.ld));
                    check("sc_success", 64'(sc_success), 64'(e.sc));
                    check("misalign", 64'(misalign), 64'(e.mis));
                end
            end
            wb_prev = wb_valid;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int       kind;
        logic [31:0] a;
        bus_exp_t b;
        rst_n = 1'b0;
        pipe_stall = 1'b0; mem_read = 1'b0; mem_write = 1'b0; atomic = 1'b0;
        zero_ext = 1'b0; m_size = 2'b00; addr = '0; rt_data = '0;
        arb_gnt = 1'b0; arb_rvalid = 1'b0; arb_rdata = '0;
        snoop_valid = 1'b0; snoop_addr = '0;
        #12;
        check("rst_arb_req", 64'(arb_req), 64'(0));
        check("rst_wb_valid", 64'(wb_valid), 64'(0));
        check("rst_mem_busy", 64'(mem_busy), 64'(0));
        check("rst_load_data", 64'(load_data), 64'(0));
        check("rst_arb_we", 64'(arb_we), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Byte store to top lane, grant on second REQ cycle
        do_access(1, 2'b00, 1'b0, 32'h1003, 32'h0000_00AB, 32'h0, 1, 0, 0, 1'b0, 32'h0);
        // Half loads, signed and unsigned, data four cycles after grant
        do_access(0, 2'b01, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 0, 4, 3, 1'b0, 32'h0);
        do_access(0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'h8001_1234, 0, 4, 0, 1'b0, 32'h0);
        // Grant and rvalid together
        do_access(0, 2'b00, 1'b0, 32'h2001, 32'h0, 32'h0000_9A00, 0, 0, 0, 1'b0, 32'h0);
        // LL / SC pass, then repeated SC fails without bus traffic
        do_access(2, 2'b10, 1'b0, 32'h3000, 32'h0, 32'h1111_2222, 0, 1, 0, 1'b0, 32'h0);
        do_access(3, 2'b10, 1'b0, 32'h3000, 32'h5555_AAAA, 32'h0, 0, 0, 0, 1'b0, 32'h0);
        do_access(3, 2'b10, 1'b0, 32'h3000, 32'h5555_AAAA, 32'h0, 0, 0, 0, 1'b0, 32'h0);
        // Snoop to same granule kills the reservation
        do_access(2, 2'b10, 1'b0, 32'h3000, 32'h0, 32'h1, 0, 2, 0, 1'b0, 32'h0);
        gap_snoop(32'h3002);
        do_access(3, 2'b10, 1'b0, 32'h3000, 32'h7, 32'h0, 0, 0, 0, 1'b0, 32'h0);
        // Snoop coinciding with LL data capture wins
        do_access(2, 2'b10, 1'b0, 32'h3004, 32'h0, 32'h2, 1, 2, 0, 1'b1, 32'h3007);
        do_access(3, 2'b10, 1'b0, 32'h3004, 32'h8, 32'h0, 0, 0, 0, 1'b0, 32'h0);
        // Snoop during SC grant does not abort it
        do_access(2, 2'b10, 1'b0, 32'h3004, 32'h0, 32'h3, 0, 0, 0, 1'b0, 32'h0);
        do_access(3, 2'b10, 1'b0, 32'h3004, 32'h9, 32'h0, 2, 0, 0, 1'b1, 32'h3004);
        // Oversized request on a 32-bit bus behaves as a word
        do_access(1, 2'b11, 1'b0, 32'h1000, 32'hDEAD_BEEF, 32'h0, 0, 0, 1, 1'b0, 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
        do_access(0, 2'b10, 1'b0, 32'h4002, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 1'b0, 32'h0);
`endif

        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom % 4);
            a = pick_addr();
            if (kind == 3 && ($urandom % 2) == 0) a = last_ll;
            do_access(kind, 2'($urandom % 4), 1'($urandom % 2), a, $urandom, $urandom,
                      int'($urandom % 3), int'($urandom % 4),
                      (($urandom % 4) == 0) ? int'($urandom % 3) : 0,
                      ($urandom % 4) == 0, pick_addr());
            if (($urandom % 4) == 0) gap_snoop(pick_addr());
        end

        // Reset while a store sits in REQ, then verify the reservation is gone
        do_access(2, 2'b10, 1'b0, 32'h3000, 32'h0, 32'h0000_0001, 0, 1, 0, 1'b0, 32'h0);
        b.addr = 32'h5000; b.we = 4'hF; b.wdata = 32'hCAFE_F00D; b.chk_wd = 1'b1;
        bus_q.push_back(b);
        @(negedge clk);
        mem_write = 1'b1; m_size = 2'b10; addr = 32'h5000; rt_data = 32'hCAFE_F00D;
        @(negedge clk);
        mem_write = 1'b0;
        check("rst_pre_req", 64'(arb_req), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_arb_req", 64'(arb_req), 64'(0));
        check("rst_mid_mem_busy", 64'(mem_busy), 64'(0));
        check("rst_mid_wb_valid", 64'(wb_valid), 64'(0));
        check("rst_mid_arb_addr", 64'(arb_addr), 64'(0));
        check("rst_mid_arb_we", 64'(arb_we), 64'(0));
        check("rst_mid_arb_wdata", 64'(arb_wdata), 64'(0));
        check("rst_mid_load_data", 64'(load_data), 64'(0));
        check("rst_mid_sc_success", 64'(sc_success), 64'(0));
        check("rst_mid_misalign", 64'(misalign), 64'(0));
        resv_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_access(3, 2'b10, 1'b0, 32'h3000, 32'h4, 32'h0, 0, 0, 0, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        check("bus_q_drained", 64'(bus_q.size()), 64'(0));
        check("res_q_drained", 64'(res_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
